uart_rx: RTL and testbench

- Serial receiver that sits directly upstream of the UART-to-ALU command interface.
- Oversamples the asynchronous RX line using a 16x baud tick from the shared baud-rate generator.
- Deframes 8N1 characters, LSB first.
- Presents each received byte on o_data with a single-cycle o_rx_done strobe, which the interface consumes as its data/done pair.

---
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. Deframes LSB-first characters from
// a synchronized RX line and strobes each good byte (or a framing error) for one clk.
module uart_rx #(
  parameter int NB_DATA     = 8,
  parameter int NB_STOP     = 16,
  parameter int NB_TICK_CNT = 4
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int NB_BIT_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_TICK_CNT-1:0] TICK_MID  = NB_TICK_CNT'(7);
  localparam logic [NB_TICK_CNT-1:0] TICK_LAST = NB_TICK_CNT'(15);
  localparam logic [NB_TICK_CNT-1:0] TICK_STOP = NB_TICK_CNT'(NB_STOP - 1);
  localparam logic [NB_BIT_CNT-1:0]  BIT_LAST  = NB_BIT_CNT'(NB_DATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchronizer flops reset high so a reset never looks like a start edge.
  logic rx_meta_q;
  logic rx_s_q;

  state_t                 state_q,    state_d;
  logic [NB_TICK_CNT-1:0] tick_cnt_q, tick_cnt_d;
  logic [NB_BIT_CNT-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [NB_DATA-1:0]     shreg_q,    shreg_d;
  logic [NB_DATA-1:0]     data_q,     data_d;
  logic                   done_q,     done_d;
  logic                   ferr_q,     ferr_d;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      // Start detection runs every clk, independent of the tick.
      IDLE: begin
        if (!rx_s_q) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end

      START: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shreg_d    = {rx_s_q, shreg_q[NB_DATA-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + NB_BIT_CNT'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_STOP) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = IDLE;
            if (rx_s_q) begin
              data_d = shreg_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes, a monitor
// pops and compares whenever the receiver reports a byte or framing error.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests     = 0;
  int   n_fail      = 0;
  int   n_done_seen = 0;
  int   n_done_exp  = 0;
  bit   tick_en     = 1'b0;
  bit   mon_en      = 1'b0;
  logic prev_busy   = 1'b0;

  uart_rx dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_tick     (i_tick),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_strobe(input logic is_err, input logic [7:0] b);
    exp_t e;
    e.is_err = is_err;
    e.data   = b;
    exp_q.push_back(e);
    if (!is_err) n_done_exp++;
  endtask

  // One 8N1 frame; stop level/length adjustable, optional tick stall inside a data bit.
  task automatic send(input logic [7:0] b, input logic stop_v, input int stop_clk,
                      input int pause_bit);
    i_rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      if (i == pause_bit) begin
        wait_clk(32);
        tick_en = 1'b0;
        wait_clk(100);
        check("busy_while_stalled", 32'(o_busy), 1);
        wait_clk(100);
        tick_en = 1'b1;
        wait_clk(32);
      end else begin
        wait_clk(BIT_CLK);
      end
    end
    i_rx = stop_v;
    wait_clk(stop_clk);
    i_rx = 1'b1;
  endtask

  // 16x tick: one clk wide, every 4 clk, phase preserved across stalls.
  initial begin
    int div;
    div    = 0;
    i_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        div    = (div + 1) % 4;
        i_tick = (div == 0);
      end else begin
        i_tick = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_rx_done && o_frame_err)
        check("strobes_exclusive", 1, 0);
      if (o_rx_done || o_frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {22'd0, o_frame_err, o_rx_done, o_data}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          if (o_rx_done) n_done_seen++;
          check("strobe_kind", {30'd0, o_frame_err, o_rx_done}, {30'd0, mon_e.is_err, !mon_e.is_err});
          check(mon_e.is_err ? "data_held_on_ferr" : "rx_data", 32'(o_data), 32'(mon_e.data));
          check("busy_falls_with_strobe", {30'd0, prev_busy, o_busy}, 32'b10);
          $display("[TB] %s got 0x%02h expected 0x%02h", mon_e.is_err ? "frame_err" : "rx_done ",
                   o_data, mon_e.data);
        end
      end
    end
    prev_busy <= o_busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish first");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b2b [6];
    logic [7:0] c3;
    b2b = '{8'h08, 8'h3C, 8'h10, 8'h7F, 8'h20, 8'h20};
    c3  = 8'hC3;

    i_rst = 1'b1;
    i_rx  = 1'b1;
    wait_clk(4);
    check("reset_data",  32'(o_data), 0);
    check("reset_done",  32'(o_rx_done), 0);
    check("reset_ferr",  32'(o_frame_err), 0);
    check("reset_busy",  32'(o_busy), 0);
    i_rst   = 1'b0;
    mon_en  = 1'b1;
    tick_en = 1'b1;
    wait_clk(20);

    // Single good frame.
    expect_strobe(1'b0, 8'hA5);
    send(8'hA5, 1'b1, BIT_CLK, -1);
    wait_clk(2 * BIT_CLK);
    check("drained_a5", 32'(exp_q.size()), 0);

    // Back-to-back frames, no idle gap.
    foreach (b2b[i]) expect_strobe(1'b0, b2b[i]);
    foreach (b2b[i]) send(b2b[i], 1'b1, BIT_CLK, -1);
    wait_clk(2 * BIT_CLK);
    check("drained_b2b", 32'(exp_q.size()), 0);

    // Start glitch shorter than half a bit.
    i_rx = 1'b0;
    wait_clk(12);
    i_rx = 1'b1;
    wait_clk(BIT_CLK);
    check("glitch_busy", 32'(o_busy), 0);
    check("glitch_data_held", 32'(o_data), 32'h20);

    // Framing error: stop held low long enough to be sampled, then released
    // so the re-entered START sees a glitch.
    expect_strobe(1'b0, 8'hA5);
    send(8'hA5, 1'b1, BIT_CLK, -1);
    expect_strobe(1'b1, 8'hA5);
    send(8'h55, 1'b0, 48, -1);
    wait_clk(2 * BIT_CLK);
    check("ferr_busy", 32'(o_busy), 0);
    check("ferr_data_held", 32'(o_data), 32'hA5);
    expect_strobe(1'b0, 8'h12);
    send(8'h12, 1'b1, BIT_CLK, -1);
    wait_clk(2 * BIT_CLK);

    // Reset in the middle of data bit 4 of 0xC3.
    i_rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      i_rx = c3[i];
      wait_clk(BIT_CLK);
    end
    i_rx = c3[4];
    wait_clk(32);
    check("busy_before_reset", 32'(o_busy), 1);
    i_rst = 1'b1;
    i_rx  = 1'b1;
    wait_clk(1);
    check("midreset_data", 32'(o_data), 0);
    check("midreset_done", 32'(o_rx_done), 0);
    check("midreset_ferr", 32'(o_frame_err), 0);
    check("midreset_busy", 32'(o_busy), 0);
    i_rst = 1'b0;
    wait_clk(BIT_CLK);
    check("postreset_busy", 32'(o_busy), 0);
    expect_strobe(1'b0, 8'h81);
    send(8'h81, 1'b1, BIT_CLK, -1);
    wait_clk(2 * BIT_CLK);

    // Tick stall mid-DATA.
    expect_strobe(1'b0, 8'h5A);
    send(8'h5A, 1'b1, BIT_CLK, 3);
    wait_clk(2 * BIT_CLK);
    check("final_data", 32'(o_data), 32'h5A);

    check("pending_expectations", 32'(exp_q.size()), 0);
    check("done_count", 32'(n_done_seen), 32'(n_done_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
